// File: rtl/oled_spi_streamer_if.sv
// Pixel-source request/response bus and SSD1306 4-wire SPI pins for oled_spi_streamer.
interface oled_spi_streamer_if;
  logic [7:0] data_to_send;
  logic [9:0] byte_counter;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       spi_dc;
  logic       oled_rst_n;
  logic       frame_done;
  logic       busy_init;

  modport master (
    input  data_to_send,
    output byte_counter, spi_sclk, spi_mosi, spi_cs_n, spi_dc,
           oled_rst_n, frame_done, busy_init
  );

  modport slave (
    output data_to_send,
    input  byte_counter, spi_sclk, spi_mosi, spi_cs_n, spi_dc,
           oled_rst_n, frame_done, busy_init
  );
endinterface

// File: rtl/oled_spi_streamer.sv
// SSD1306 128x64 driver: panel reset, init command list, then endless WINDOW+DATA frame streaming.
// Optional macro TEST_PATTERN_EN adds a test_pattern input that replaces pixel data with AA/55.
module oled_spi_streamer #(
  parameter int CLK_DIV     = 4,
  parameter int RST_CYCLES  = 1000,
  parameter int PWR_CYCLES  = 1000,
  parameter int FRAME_BYTES = 1024
) (
  input  logic clk,
  input  logic rst,
`ifdef TEST_PATTERN_EN
  input  logic test_pattern,
`endif
  oled_spi_streamer_if.master bus
);

  localparam int              DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [31:0]     RST_LAST   = 32'(RST_CYCLES - 1);
  localparam logic [31:0]     PWR_LAST   = 32'(PWR_CYCLES - 1);
  localparam logic [31:0]     GAP_LAST   = 32'(2 * CLK_DIV - 1);
  localparam logic [9:0]      FRAME_LAST = 10'(FRAME_BYTES - 1);
  localparam logic [4:0]      INIT_LAST  = 5'd24;
  localparam logic [4:0]      WIN_LAST   = 5'd5;

  typedef enum logic [2:0] {PANEL_RST, PWR_WAIT, INIT, WINDOW, DATA, GAP} state_t;

  state_t           state;
  logic [31:0]      wait_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [4:0]       byte_idx;
  logic [7:0]       shreg;
  logic [9:0]       byte_counter;
  logic [9:0]       bc_next;
  logic             sclk, cs_n, dc, oled_rst_n, frame_done, busy_init;
  logic [7:0]       data_byte;
  logic [7:0]       next_byte;

  function automatic logic [7:0] init_rom(input logic [4:0] idx);
    case (idx)
      5'd0:  return 8'hAE;  5'd1:  return 8'hD5;  5'd2:  return 8'h80;
      5'd3:  return 8'hA8;  5'd4:  return 8'h3F;  5'd5:  return 8'hD3;
      5'd6:  return 8'h00;  5'd7:  return 8'h40;  5'd8:  return 8'h8D;
      5'd9:  return 8'h14;  5'd10: return 8'h20;  5'd11: return 8'h00;
      5'd12: return 8'hA1;  5'd13: return 8'hC8;  5'd14: return 8'hDA;
      5'd15: return 8'h12;  5'd16: return 8'h81;  5'd17: return 8'hCF;
      5'd18: return 8'hD9;  5'd19: return 8'hF1;  5'd20: return 8'hDB;
      5'd21: return 8'h40;  5'd22: return 8'hA4;  5'd23: return 8'hA6;
      5'd24: return 8'hAF;
      default: return 8'h00;
    endcase
  endfunction

  // Column range 0..127, page range 0..7: the whole panel in horizontal addressing.
  function automatic logic [7:0] window_rom(input logic [4:0] idx);
    case (idx)
      5'd0: return 8'h21;  5'd1: return 8'h00;  5'd2: return 8'h7F;
      5'd3: return 8'h22;  5'd4: return 8'h00;  5'd5: return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
`ifdef TEST_PATTERN_EN
    data_byte = test_pattern ? (byte_counter[0] ? 8'h55 : 8'hAA) : bus.data_to_send;
`else
    data_byte = bus.data_to_send;
`endif
  end

  always_comb begin
    bc_next = (byte_counter == FRAME_LAST) ? 10'd0 : byte_counter + 10'd1;
  end

  // Byte to load at the next byte boundary of the current state.
  always_comb begin
    next_byte = 8'h00;
    case (state)
      PWR_WAIT: next_byte = init_rom(5'd0);
      INIT:     next_byte = (byte_idx == INIT_LAST) ? window_rom(5'd0) : init_rom(byte_idx + 5'd1);
      WINDOW:   next_byte = (byte_idx == WIN_LAST) ? data_byte : window_rom(byte_idx + 5'd1);
      DATA:     next_byte = data_byte;
      GAP:      next_byte = window_rom(5'd0);
      default:  next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PANEL_RST;
      wait_cnt     <= 32'd0;
      div_cnt      <= '0;
      bit_cnt      <= 3'd0;
      byte_idx     <= 5'd0;
      shreg        <= 8'h00;
      byte_counter <= 10'd0;
      sclk         <= 1'b0;
      cs_n         <= 1'b1;
      dc           <= 1'b0;
      oled_rst_n   <= 1'b0;
      frame_done   <= 1'b0;
      busy_init    <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      case (state)
        PANEL_RST: begin
          if (wait_cnt == RST_LAST) begin
            wait_cnt   <= 32'd0;
            oled_rst_n <= 1'b1;
            state      <= PWR_WAIT;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        PWR_WAIT: begin
          if (wait_cnt == PWR_LAST) begin
            state    <= INIT;
            cs_n     <= 1'b0;
            dc       <= 1'b0;
            byte_idx <= 5'd0;
            shreg    <= next_byte;
            bit_cnt  <= 3'd0;
            div_cnt  <= '0;
            sclk     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        GAP: begin
          dc <= 1'b0;
          if (wait_cnt == GAP_LAST) begin
            state        <= WINDOW;
            cs_n         <= 1'b0;
            byte_idx     <= 5'd0;
            byte_counter <= 10'd0;
            shreg        <= next_byte;
            bit_cnt      <= 3'd0;
            div_cnt      <= '0;
            sclk         <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        INIT, WINDOW, DATA: begin
          // Each bit: CLK_DIV cycles low then CLK_DIV high; shift and reload only on the falling edge.
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (sclk) begin
              if (bit_cnt != 3'd7) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {shreg[6:0], 1'b0};
              end else begin
                bit_cnt  <= 3'd0;
                shreg    <= next_byte;
                byte_idx <= byte_idx + 5'd1;
                case (state)
                  INIT: begin
                    if (byte_idx == INIT_LAST) begin
                      state        <= WINDOW;
                      byte_idx     <= 5'd0;
                      busy_init    <= 1'b0;
                      byte_counter <= 10'd0;
                    end
                  end
                  WINDOW: begin
                    if (byte_idx == WIN_LAST) begin
                      state        <= DATA;
                      dc           <= 1'b1;
                      byte_counter <= bc_next;
                    end
                  end
                  DATA: begin
                    // byte_counter wrapped to 0 when the final byte was loaded.
                    if (byte_counter == 10'd0) begin
                      state      <= GAP;
                      cs_n       <= 1'b1;
                      wait_cnt   <= 32'd0;
                      shreg      <= 8'h00;
                      frame_done <= 1'b1;
                    end else begin
                      byte_counter <= bc_next;
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
        end
        default: state <= PANEL_RST;
      endcase
    end
  end

  assign bus.byte_counter = byte_counter;
  assign bus.spi_sclk     = sclk;
  assign bus.spi_mosi     = shreg[7];
  assign bus.spi_cs_n     = cs_n;
  assign bus.spi_dc       = dc;
  assign bus.oled_rst_n   = oled_rst_n;
  assign bus.frame_done   = frame_done;
  assign bus.busy_init    = busy_init;

endmodule

// File: tb/tb_oled_spi_streamer.sv
// Directed bench for oled_spi_streamer: reset, init list, two frames, frame gap, mid-frame reset.
// Short reset/power waits and CLK_DIV=1 keep the run small while frames stay 1024 bytes.
module tb_oled_spi_streamer;
  localparam int CLK_DIV     = 1;
  localparam int RST_CYCLES  = 20;
  localparam int PWR_CYCLES  = 15;
  localparam int FRAME_BYTES = 1024;
  localparam int BYTE_CLKS   = 16 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef TEST_PATTERN_EN
  logic test_pattern = 1'b0;
`endif

  oled_spi_streamer_if bus();

  oled_spi_streamer #(
    .CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES),
    .PWR_CYCLES(PWR_CYCLES), .FRAME_BYTES(FRAME_BYTES)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Upstream memory: byte value equals its index, one clock of registered latency.
  always @(posedge clk) bus.data_to_send <= bus.byte_counter[7:0];

  logic [7:0] init_list [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                                 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                                 8'hAF};
  logic [7:0] win_list [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // SPI monitor state: decoded bytes carry {dc, data}.
  logic [8:0] rx_q [$];
  int         fd_q [$];
  int         gap_q [$];
  logic [7:0] sh;
  int         nbits = 0;
  int         wrap_cnt = 0;
  int         busy_fall_rx = -1;
  int         bad_rise = 0;
  int         hi_run = 0;
  bit         seen_low = 1'b0;
  logic       prev_sclk, prev_busy;
  logic [9:0] prev_bc;

  always @(negedge clk) begin
    if (rst) begin
      rx_q.delete();
      fd_q.delete();
      gap_q.delete();
      nbits        = 0;
      wrap_cnt     = 0;
      busy_fall_rx = -1;
      hi_run       = 0;
      seen_low     = 1'b0;
    end else begin
      if (bus.spi_sclk && !prev_sclk) begin
        if (bus.spi_cs_n) bad_rise++;
        else begin
          sh = {sh[6:0], bus.spi_mosi};
          nbits++;
          if (nbits == 8) begin
            rx_q.push_back({bus.spi_dc, sh});
            nbits = 0;
          end
        end
      end
      if (bus.frame_done) fd_q.push_back(rx_q.size());
      if (prev_busy && !bus.busy_init) busy_fall_rx = rx_q.size();
      if (prev_bc == 10'd1023 && bus.byte_counter == 10'd0) wrap_cnt++;
      if (bus.spi_cs_n) hi_run++;
      else begin
        if (seen_low && hi_run > 0) gap_q.push_back(hi_run);
        hi_run   = 0;
        seen_low = 1'b1;
      end
    end
    prev_sclk = bus.spi_sclk;
    prev_busy = bus.busy_init;
    prev_bc   = bus.byte_counter;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_rx(input int n, input string tag);
    int budget;
    budget = (n - rx_q.size()) * BYTE_CLKS + 20 * BYTE_CLKS + RST_CYCLES + PWR_CYCLES + 200;
    while (rx_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_output(tag, 32'(rx_q.size() >= n), 32'd1);
  endtask

  initial begin
    int low_cnt, hi_cnt, idle_bad, errs, guard;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_byte_counter", 32'(bus.byte_counter), 32'd0);
    check_output("rst_sclk",         32'(bus.spi_sclk),     32'd0);
    check_output("rst_mosi",         32'(bus.spi_mosi),     32'd0);
    check_output("rst_cs_n",         32'(bus.spi_cs_n),     32'd1);
    check_output("rst_dc",           32'(bus.spi_dc),       32'd0);
    check_output("rst_oled_rst_n",   32'(bus.oled_rst_n),   32'd0);
    check_output("rst_frame_done",   32'(bus.frame_done),   32'd0);
    check_output("rst_busy_init",    32'(bus.busy_init),    32'd1);

    rst = 1'b0;
    low_cnt  = 0;
    idle_bad = 0;
    while (bus.oled_rst_n === 1'b0 && low_cnt < 500) begin
      if (bus.spi_cs_n !== 1'b1 || bus.spi_sclk !== 1'b0 || bus.busy_init !== 1'b1) idle_bad++;
      low_cnt++;
      @(negedge clk);
    end
    check_output("panel_rst_low_cycles", 32'(low_cnt), 32'd20);
    check_output("panel_rst_idle_pins", 32'(idle_bad), 32'd0);

    hi_cnt = 0;
    while (bus.spi_cs_n === 1'b1 && hi_cnt < 500) begin
      hi_cnt++;
      @(negedge clk);
    end
    check_output("pwr_wait_cycles", 32'(hi_cnt), 32'd15);

    wait_rx(25, "init_arrival");
    for (int i = 0; i < 25; i++)
      check_output($sformatf("init_byte%0d", i), 32'(rx_q[i]), {23'd0, 1'b0, init_list[i]});
    repeat (4) @(negedge clk);
    check_output("busy_fall_after_af", 32'(busy_fall_rx), 32'd25);

    wait_rx(31, "window1_arrival");
    for (int i = 0; i < 6; i++)
      check_output($sformatf("window1_byte%0d", i), 32'(rx_q[25 + i]), {23'd0, 1'b0, win_list[i]});

    wait_rx(1055, "frame1_arrival");
    errs = 0;
    for (int i = 0; i < 1024; i++)
      if (rx_q[31 + i] !== {1'b1, 8'(i)}) errs++;
    check_output("frame1_data_errors", 32'(errs), 32'd0);
    repeat (2 * BYTE_CLKS) @(negedge clk);
    check_output("frame1_done_count", 32'(fd_q.size()), 32'd1);
    check_output("frame1_done_position", 32'(fd_q[0]), 32'd1055);
    check_output("frame1_counter_wrap", 32'(wrap_cnt), 32'd1);

    wait_rx(2085, "frame2_arrival");
    for (int i = 0; i < 6; i++)
      check_output($sformatf("window2_byte%0d", i), 32'(rx_q[1055 + i]), {23'd0, 1'b0, win_list[i]});
    errs = 0;
    for (int i = 0; i < 1024; i++)
      if (rx_q[1061 + i] !== {1'b1, 8'(i)}) errs++;
    check_output("frame2_data_errors", 32'(errs), 32'd0);
    repeat (4) @(negedge clk);
    check_output("frame2_done_count", 32'(fd_q.size()), 32'd2);
    check_output("frame2_done_position", 32'(fd_q[1]), 32'd2085);
    check_output("frame_gap_cycles", 32'(gap_q[0]), 32'(2 * CLK_DIV));
    check_output("frame2_counter_wrap", 32'(wrap_cnt), 32'd2);

    wait_rx(2085 + 6 + 500, "frame3_byte500_arrival");
    @(negedge clk);
    guard = 0;
    while (bus.spi_sclk !== 1'b1 && guard < 4 * CLK_DIV) begin
      guard++;
      @(negedge clk);
    end
    check_output("mid_frame_counter", 32'(bus.byte_counter), 32'd501);
    rst = 1'b1;
    @(negedge clk);
    check_output("abort_cs_n",         32'(bus.spi_cs_n),     32'd1);
    check_output("abort_sclk",         32'(bus.spi_sclk),     32'd0);
    check_output("abort_oled_rst_n",   32'(bus.oled_rst_n),   32'd0);
    check_output("abort_byte_counter", 32'(bus.byte_counter), 32'd0);
    check_output("abort_busy_init",    32'(bus.busy_init),    32'd1);
    @(negedge clk);
    rst = 1'b0;

    wait_rx(25, "reinit_arrival");
    errs = 0;
    for (int i = 0; i < 25; i++)
      if (rx_q[i] !== {1'b0, init_list[i]}) errs++;
    check_output("reinit_errors", 32'(errs), 32'd0);
    repeat (4) @(negedge clk);
    check_output("reinit_busy_fall", 32'(busy_fall_rx), 32'd25);

`ifdef TEST_PATTERN_EN
    test_pattern = 1'b1;
    wait_rx(25 + 6 + 16, "pattern_arrival");
    for (int i = 0; i < 16; i++)
      check_output($sformatf("pattern_byte%0d", i), 32'(rx_q[31 + i]),
                   {23'd0, 1'b1, ((i % 2) == 0) ? 8'hAA : 8'h55});
`endif

    check_output("sclk_rise_with_cs_high", 32'(bad_rise), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
